// File: rtl/dsg_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module      : dsg_dac_serializer
// Description : Buffers generator samples in a small FIFO and shifts each one
//               MSB-first to an SPI-style serial DAC, one chip-select frame
//               per sample, with fill level, busy and sticky overflow status.
//               Optional build macro DSG_SER_OFFSET_BINARY_EN inverts the MSB
//               of every popped sample (two's-complement to offset-binary).
// Revision    : 1.0 - initial release
// ============================================================================
module dsg_dac_serializer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int CLKDIV = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [WIDTH-1:0]         Sin,
  input  logic                     Sin_valid,
  output logic                     Sin_ready,
  input  logic                     Enable,
  input  logic                     Clr_ovf,
  output logic                     Dac_csn,
  output logic                     Dac_sclk,
  output logic                     Dac_sdo,
  output logic                     Busy,
  output logic [$clog2(DEPTH):0]   Fill,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_ZERO = '0;
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // FIFO storage and status
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             ovf_q,  ovf_d;

  // Serializer state
  state_t           state_q, state_d;
  logic [DW-1:0]    div_q,   div_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             csn_q,   csn_d;
  logic             sclk_q,  sclk_d;
  logic             sdo_q,   sdo_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             drop;
  logic             pop;
  logic             start;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] load_word;

  // Ready is taken from registered full only, so a same-cycle pop never
  // admits a write into a full FIFO.
  assign full  = (fill_q == FILL_FULL);
  assign empty = (fill_q == FILL_ZERO);
  assign push  = Sin_valid && !full;
  assign drop  = Sin_valid && full;
  assign head  = mem[rptr_q];

`ifdef DSG_SER_OFFSET_BINARY_EN
  assign load_word = {~head[WIDTH-1], head[WIDTH-2:0]};
`else
  assign load_word = head;
`endif

  // Sample storage: written on every accepted push, no reset needed
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wptr_q] <= Sin;
    end
  end

  // FIFO pointer, occupancy and sticky overflow next-state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    ovf_d  = ovf_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
    // A new drop outranks a clear in the same cycle
    if (drop) begin
      ovf_d = 1'b1;
    end else if (Clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Frame sequencer: divider-paced SCLK phases, bit count and chip select
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    start   = 1'b0;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Enable && !empty) begin
          start = 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              csn_d   = 1'b1;
              sdo_d   = 1'b0;
              state_d = S_GAP;
            end else begin
              bit_d   = bit_q + BIT_ONE;
              sdo_d   = shreg_q[WIDTH-2];
              shreg_d = shreg_q << 1;
            end
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (Enable && !empty) begin
            start = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame launch is shared by IDLE and the end of GAP
    if (start) begin
      pop     = 1'b1;
      shreg_d = load_word;
      sdo_d   = load_word[WIDTH-1];
      csn_d   = 1'b0;
      sclk_d  = 1'b0;
      bit_d   = '0;
      div_d   = '0;
      state_d = S_SHIFT;
    end
  end

  // State and FIFO registers; reset aborts any frame immediately
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sin_ready = !full;
  assign Busy      = (state_q != S_IDLE);
  assign Fill      = fill_q;
  assign Overflow  = ovf_q;
  assign Dac_csn   = csn_q;
  assign Dac_sclk  = sclk_q;
  assign Dac_sdo   = sdo_q;

endmodule
`default_nettype wire
